// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and header decode for the router output buffers
package router_pkg;

   localparam int ROUTER_DATA_W     = 8;
   localparam int ROUTER_FIFO_DEPTH = 16;
   localparam int ROUTER_LEN_W      = 6;

   // The payload length occupies the upper six bits of the header byte.
   function automatic logic [ROUTER_LEN_W-1:0] hdr_len(input logic [7:0] hdr);
      return hdr[7:2];
   endfunction

endpackage

// File: rtl/router_fifo_if.sv
// rtl/router_fifo_if.sv - write/read handshake bundle between the router core and one output buffer
interface router_fifo_if
   import router_pkg::*;
#(
   parameter int WIDTH = ROUTER_DATA_W
);

   logic             write_enb;
   logic             read_enb;
   logic             lfd_state;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             rd_valid;
   logic             pkt_last;
   logic             full;
   logic             empty;

   modport master (
      output write_enb, read_enb, lfd_state, data_in,
      input  data_out, rd_valid, pkt_last, full, empty
   );

   modport slave (
      input  write_enb, read_enb, lfd_state, data_in,
      output data_out, rd_valid, pkt_last, full, empty
   );

endinterface

// File: rtl/router_fifo_ptr.sv
// rtl/router_fifo_ptr.sv - wrap-bit pointers, full/empty flags and qualified read/write strobes
module router_fifo_ptr
   import router_pkg::*;
#(
   parameter int DEPTH = ROUTER_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     soft_reset,
   input  logic                     write_enb,
   input  logic                     read_enb,
   output logic                     wr_fire,
   output logic                     rd_fire,
   output logic [$clog2(DEPTH)-1:0] wr_addr,
   output logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic                     full,
   output logic                     empty
);

   localparam int         AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A flush wins over any transfer in the same cycle.
   assign wr_fire = write_enb && !full && !soft_reset;
   assign rd_fire = read_enb && !empty && !soft_reset;

   assign wr_addr = wr_ptr[AW-1:0];
   assign rd_addr = rd_ptr[AW-1:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (soft_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

endmodule

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - per-destination output buffer with header marking and packet-end detection
module router_fifo
   import router_pkg::*;
#(
   parameter int WIDTH = ROUTER_DATA_W,
   parameter int DEPTH = ROUTER_FIFO_DEPTH
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           soft_reset,
   router_fifo_if.slave   bus
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = ROUTER_LEN_W + 1;

   logic [WIDTH-1:0] mem_data [DEPTH];
   logic             mem_mark [DEPTH];

   logic             wr_fire;
   logic             rd_fire;
   logic [AW-1:0]    wr_addr;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_byte;
   logic             rd_mark;
   logic [CNT_W-1:0] count;

   router_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
      .clk        (clk),
      .resetn     (resetn),
      .soft_reset (soft_reset),
      .write_enb  (bus.write_enb),
      .read_enb   (bus.read_enb),
      .wr_fire    (wr_fire),
      .rd_fire    (rd_fire),
      .wr_addr    (wr_addr),
      .rd_addr    (rd_addr),
      .full       (bus.full),
      .empty      (bus.empty)
   );

   always_ff @(posedge clk) begin
      if (wr_fire) mem_data[wr_addr] <= bus.data_in;
   end

   // Marker bits are cleared on flush so a stale header can never restart length tracking.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) mem_mark[i] <= 1'b0;
      end else if (soft_reset) begin
         for (int i = 0; i < DEPTH; i++) mem_mark[i] <= 1'b0;
      end else if (wr_fire) begin
         mem_mark[wr_addr] <= bus.lfd_state;
      end
   end

   assign rd_byte = mem_data[rd_addr];
   assign rd_mark = mem_mark[rd_addr];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.data_out <= '0;
         bus.rd_valid <= 1'b0;
         bus.pkt_last <= 1'b0;
         count        <= '0;
      end else if (soft_reset) begin
         bus.data_out <= '0;
         bus.rd_valid <= 1'b0;
         bus.pkt_last <= 1'b0;
         count        <= '0;
      end else begin
         bus.rd_valid <= rd_fire;
         bus.pkt_last <= 1'b0;
         if (rd_fire) begin
            bus.data_out <= rd_byte;
            // Header loads payload length plus one for the trailing parity byte.
            if (rd_mark) begin
               count <= CNT_W'(hdr_len(rd_byte[7:0])) + CNT_W'(1);
            end else if (count != '0) begin
               bus.pkt_last <= (count == CNT_W'(1));
               count        <= count - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - scoreboard bench for router_fifo against a queue-based packet model
module tb_router_fifo;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic soft_reset = 1'b0;

   always #5 clk = ~clk;

   router_fifo_if #(.WIDTH(8)) bus ();

   router_fifo #(.WIDTH(8), .DEPTH(16)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .soft_reset (soft_reset),
      .bus        (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [8:0] mq [$];
   logic [8:0] exp_q [$];
   int         cnt = 0;
   bit         prev_fire = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      exp_q.delete();
      cnt = 0;
      prev_fire = 1'b0;
   endtask

   // One clock: check flags and valid against the model, drive inputs, advance the model.
   task automatic cycle(input bit we, input bit re, input bit lfd, input logic [7:0] d, input bit sr);
      bit         wf;
      bit         rf;
      logic [8:0] w;
      bit         last;
      chk("rd_valid", 32'(bus.rd_valid), 32'(prev_fire));
      chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
      chk("full", 32'(bus.full), 32'(mq.size() == 16));
      bus.write_enb = we;
      bus.read_enb  = re;
      bus.lfd_state = lfd;
      bus.data_in   = d;
      soft_reset    = sr;
      if (sr) begin
         mq.delete();
         cnt = 0;
         prev_fire = 1'b0;
      end else begin
         wf = we && (mq.size() < 16);
         rf = re && (mq.size() > 0);
         if (rf) begin
            w = mq.pop_front();
            last = 1'b0;
            if (w[8]) begin
               cnt = int'(w[7:2]) + 1;
            end else if (cnt != 0) begin
               last = (cnt == 1);
               cnt--;
            end
            exp_q.push_back({last, w[7:0]});
         end
         if (wf) mq.push_back({lfd, d});
         prev_fire = rf;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   always @(negedge clk) begin
      logic [8:0] e;
      if (resetn && bus.rd_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_read", 32'(bus.data_out), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("read_data_last", 32'({bus.pkt_last, bus.data_out}), 32'(e));
         end
      end
   end

   initial begin
      logic [7:0] pkt1 [5];
      pkt1[0] = 8'h0E; pkt1[1] = 8'hA1; pkt1[2] = 8'hA2; pkt1[3] = 8'hA3; pkt1[4] = 8'h5F;
      bus.write_enb = 1'b0;
      bus.read_enb  = 1'b0;
      bus.lfd_state = 1'b0;
      bus.data_in   = 8'h00;
      repeat (2) @(negedge clk);
      chk("reset_empty", 32'(bus.empty), 32'd1);
      chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      idle(2);

      // single packet, pkt_last only with the parity byte
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, i == 0, pkt1[i], 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      idle(2);

      // overflow: the 17th byte is dropped
      for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 1'b0, 8'(i), 1'b0);
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      idle(2);

      // concurrent traffic across the pointer wrap
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      idle(2);

      // read and write together on an empty buffer: no fall-through
      cycle(1'b1, 1'b1, 1'b0, 8'h77, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      idle(2);

      // soft reset mid-packet, then a fresh length-1 packet
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, i == 0, pkt1[i], 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 8'hEE, 1'b1);
      idle(1);
      cycle(1'b1, 1'b0, 1'b1, 8'h04, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 8'h3C, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 8'hC3, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      idle(2);

      // zero-length header: the very next byte is the last
      cycle(1'b1, 1'b0, 1'b1, 8'h03, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 8'h99, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      idle(2);

      // randomized traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
               $urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 59) == 0);
      end
      idle(2);

      // asynchronous reset while holding data
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'hB0 + i), 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      #2 resetn = 1'b0;
      #1;
      chk("async_empty", 32'(bus.empty), 32'd1);
      chk("async_full", 32'(bus.full), 32'd0);
      chk("async_data_out", 32'(bus.data_out), 32'd0);
      chk("async_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("async_pkt_last", 32'(bus.pkt_last), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      model_clear();
      @(negedge clk);
      cycle(1'b1, 1'b0, 1'b0, 8'h5A, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      idle(2);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
